// File: rtl/eh2_pkg.sv
// Shared types and the history shift helper for the branch predictor GHR tracker.
package eh2_pkg;

    localparam int GHR_SIZE_DEF   = 8;
    localparam int CKPT_DEPTH_DEF = 4;

    typedef logic [GHR_SIZE_DEF-1:0]            ghr_t;
    typedef logic [$clog2(CKPT_DEPTH_DEF)-1:0]  ghr_ckpt_id_t;

    // Newest direction enters at bit 0.
    function automatic ghr_t ghr_shift(input ghr_t old, input logic dir);
        return {old[GHR_SIZE_DEF-2:0], dir};
    endfunction

endpackage

// File: rtl/eh2_bp_ghr_thread.sv
// Single-thread history context: speculative GHR, committed GHR and the
// checkpoint ring that lets a mispredict or flush rewind the speculative copy.
module eh2_bp_ghr_thread
    import eh2_pkg::*;
#(
    parameter int CKPT_DEPTH = CKPT_DEPTH_DEF,
    localparam int PW = $clog2(CKPT_DEPTH)
)
(
    input  logic          clk,
    input  logic          rst_l,
    input  logic          pred_valid,
    input  logic          pred_taken,
    output logic          pred_ready,
    output logic [PW-1:0] pred_ckpt_id,
    input  logic          retire_valid,
    input  logic          retire_taken,
    input  logic          mispred_valid,
    input  logic [PW-1:0] mispred_id,
    input  logic          mispred_taken,
    input  logic          flush_valid,
    output ghr_t          ghr,
    output logic          ckpt_full,
    output logic          ckpt_empty
);

    localparam logic [PW:0] ONE = (PW+1)'(1);

    ghr_t        ghr_spec;
    ghr_t        ghr_commit;
    ghr_t        ghr_commit_next;
    ghr_t        ckpt [CKPT_DEPTH];
    logic [PW:0] head;
    logic [PW:0] tail;
    logic [PW:0] head_next;
    logic [PW:0] count;
    logic [PW:0] mis_off;
    logic [PW:0] mis_tail;
    logic        retire_ok;
    logic        mis_hit;
    logic        pred_fire;

    assign ckpt_empty   = (head == tail);
    assign ckpt_full    = (head[PW-1:0] == tail[PW-1:0]) && (head[PW] != tail[PW]);
    assign pred_ready   = !ckpt_full && !mispred_valid && !flush_valid;
    assign pred_ckpt_id = tail[PW-1:0];
    assign pred_fire    = pred_valid && pred_ready;
    assign ghr          = ghr_spec;

    assign retire_ok       = retire_valid && !ckpt_empty;
    assign head_next       = retire_ok ? head + ONE : head;
    assign ghr_commit_next = retire_ok ? ghr_shift(ghr_commit, retire_taken) : ghr_commit;

    // Distance from head decides membership; the rebuilt tail inherits the
    // correct wrap bit by adding that distance back onto head.
    assign count    = tail - head;
    assign mis_off  = {1'b0, mispred_id - head[PW-1:0]};
    assign mis_hit  = mispred_valid && (mis_off < count);
    assign mis_tail = head + mis_off + ONE;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ghr_spec   <= '0;
            ghr_commit <= '0;
            head       <= '0;
            tail       <= '0;
        end else begin
            head       <= head_next;
            ghr_commit <= ghr_commit_next;
            if (flush_valid) begin
                ghr_spec <= ghr_commit_next;
                tail     <= head_next;
            end else if (mis_hit) begin
                ghr_spec <= ghr_shift(ckpt[mispred_id], mispred_taken);
                tail     <= mis_tail;
            end else if (pred_fire) begin
                ghr_spec <= ghr_shift(ghr_spec, pred_taken);
                tail     <= tail + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pred_fire) begin
            ckpt[tail[PW-1:0]] <= ghr_spec;
        end
    end

    a_retire_nonempty: assert property (@(posedge clk) disable iff (!rst_l)
        retire_valid |-> !ckpt_empty);
    a_mispred_inflight: assert property (@(posedge clk) disable iff (!rst_l)
        mispred_valid |-> mis_hit);

endmodule

// File: rtl/eh2_bp_ghr_tracker.sv
// Per-thread global branch history tracker feeding the BHT index hash;
// decodes thread ids onto one history context per thread.
module eh2_bp_ghr_tracker
    import eh2_pkg::*;
#(
    parameter int GHR_SIZE    = GHR_SIZE_DEF,
    parameter int NUM_THREADS = 2,
    parameter int CKPT_DEPTH  = CKPT_DEPTH_DEF,
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int IW = $clog2(CKPT_DEPTH)
)
(
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic                          pred_valid,
    input  logic [TW-1:0]                 pred_tid,
    input  logic                          pred_taken,
    output logic                          pred_ready,
    output logic [IW-1:0]                 pred_ckpt_id,
    input  logic                          retire_valid,
    input  logic [TW-1:0]                 retire_tid,
    input  logic                          retire_taken,
    input  logic                          mispred_valid,
    input  logic [TW-1:0]                 mispred_tid,
    input  logic [IW-1:0]                 mispred_id,
    input  logic                          mispred_taken,
    input  logic                          flush_valid,
    input  logic [TW-1:0]                 flush_tid,
    output logic [NUM_THREADS*GHR_SIZE-1:0] ghr,
    output logic [NUM_THREADS-1:0]        ckpt_full,
    output logic [NUM_THREADS-1:0]        ckpt_empty
);

    logic [NUM_THREADS-1:0] ready_vec;
    logic [IW-1:0]          id_vec [NUM_THREADS];

    assign pred_ready   = ready_vec[pred_tid];
    assign pred_ckpt_id = id_vec[pred_tid];

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
        eh2_bp_ghr_thread #(
            .CKPT_DEPTH (CKPT_DEPTH)
        ) u_thread (
            .clk           (clk),
            .rst_l         (rst_l),
            .pred_valid    (pred_valid && (pred_tid == TW'(t))),
            .pred_taken    (pred_taken),
            .pred_ready    (ready_vec[t]),
            .pred_ckpt_id  (id_vec[t]),
            .retire_valid  (retire_valid && (retire_tid == TW'(t))),
            .retire_taken  (retire_taken),
            .mispred_valid (mispred_valid && (mispred_tid == TW'(t))),
            .mispred_id    (mispred_id),
            .mispred_taken (mispred_taken),
            .flush_valid   (flush_valid && (flush_tid == TW'(t))),
            .ghr           (ghr[t*GHR_SIZE +: GHR_SIZE]),
            .ckpt_full     (ckpt_full[t]),
            .ckpt_empty    (ckpt_empty[t])
        );
    end

endmodule

// File: tb/tb_eh2_bp_ghr_tracker.sv
// Directed bench for the GHR tracker: a queue-based history model checked every
// cycle, plus literal expectations at the interesting points.
module tb_eh2_bp_ghr_tracker;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        pred_valid, pred_tid, pred_taken;
    logic        pred_ready;
    logic [1:0]  pred_ckpt_id;
    logic        retire_valid, retire_tid, retire_taken;
    logic        mispred_valid, mispred_tid, mispred_taken;
    logic [1:0]  mispred_id;
    logic        flush_valid, flush_tid;
    logic [15:0] ghr;
    logic [1:0]  ckpt_full, ckpt_empty;

    int checks = 0;
    int errors = 0;

    eh2_bp_ghr_tracker dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .pred_valid    (pred_valid),
        .pred_tid      (pred_tid),
        .pred_taken    (pred_taken),
        .pred_ready    (pred_ready),
        .pred_ckpt_id  (pred_ckpt_id),
        .retire_valid  (retire_valid),
        .retire_tid    (retire_tid),
        .retire_taken  (retire_taken),
        .mispred_valid (mispred_valid),
        .mispred_tid   (mispred_tid),
        .mispred_id    (mispred_id),
        .mispred_taken (mispred_taken),
        .flush_valid   (flush_valid),
        .flush_tid     (flush_tid),
        .ghr           (ghr),
        .ckpt_full     (ckpt_full),
        .ckpt_empty    (ckpt_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: in-flight branches are a queue of saved pre-shift histories;
    // the tag of the i-th oldest entry is (retired count + i) mod 4.
    logic [7:0] m_spec   [2] = '{8'h00, 8'h00};
    logic [7:0] m_commit [2] = '{8'h00, 8'h00};
    int         m_head   [2] = '{0, 0};
    logic [7:0] m_q      [2][$];

    function automatic logic [7:0] sh(input logic [7:0] v, input logic d);
        return (v << 1) | {7'd0, d};
    endfunction

    always @(posedge clk) begin
        if (!rst_l) begin
            for (int t = 0; t < 2; t++) begin
                m_spec[t] = 8'h00;
                m_commit[t] = 8'h00;
                m_head[t] = 0;
                m_q[t].delete();
            end
        end else begin
            for (int t = 0; t < 2; t++) begin
                automatic bit pv = pred_valid && (pred_tid == t[0]);
                automatic bit rv = retire_valid && (retire_tid == t[0]);
                automatic bit mv = mispred_valid && (mispred_tid == t[0]);
                automatic bit fv = flush_valid && (flush_tid == t[0]);
                automatic int n = m_q[t].size();
                automatic bit rok = rv && (n > 0);
                automatic logic [7:0] cn = rok ? sh(m_commit[t], retire_taken) : m_commit[t];
                automatic int idx = (int'(mispred_id) - m_head[t] + 4) % 4;
                automatic logic [7:0] junk;
                if (fv) begin
                    m_spec[t] = cn;
                    m_q[t].delete();
                end else if (mv && idx < n) begin
                    m_spec[t] = sh(m_q[t][idx], mispred_taken);
                    while (m_q[t].size() > idx + 1) junk = m_q[t].pop_back();
                end else if (pv && n < 4 && !mv) begin
                    m_q[t].push_back(m_spec[t]);
                    m_spec[t] = sh(m_spec[t], pred_taken);
                end
                if (rok) begin
                    if (m_q[t].size() > 0) junk = m_q[t].pop_front();
                    m_head[t] = (m_head[t] + 1) % 4;
                end
                m_commit[t] = cn;
            end
        end
    end

    always @(negedge clk) begin
        automatic int pt = int'(pred_tid);
        automatic bit rdy = (m_q[pt].size() < 4)
                            && !(mispred_valid && mispred_tid == pred_tid)
                            && !(flush_valid && flush_tid == pred_tid);
        for (int t = 0; t < 2; t++) begin
            chk($sformatf("model_ghr%0d", t), int'(ghr[t*8 +: 8]), int'(m_spec[t]));
            chk($sformatf("model_full%0d", t), int'(ckpt_full[t]), int'(m_q[t].size() == 4));
            chk($sformatf("model_empty%0d", t), int'(ckpt_empty[t]), int'(m_q[t].size() == 0));
        end
        chk("model_ready", int'(pred_ready), int'(rdy));
        chk("model_id", int'(pred_ckpt_id), (m_head[pt] + m_q[pt].size()) % 4);
    end

    task automatic nx();
        @(posedge clk);
        #1;
        pred_valid = 0; pred_tid = 0; pred_taken = 0;
        retire_valid = 0; retire_tid = 0; retire_taken = 0;
        mispred_valid = 0; mispred_tid = 0; mispred_id = 0; mispred_taken = 0;
        flush_valid = 0; flush_tid = 0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        nx();
        settle();
    endtask

    task automatic pred(input bit tid, input bit dir);
        pred_valid = 1; pred_tid = tid; pred_taken = dir;
    endtask

    task automatic retire(input bit tid, input bit dir);
        retire_valid = 1; retire_tid = tid; retire_taken = dir;
    endtask

    task automatic mispred(input bit tid, input logic [1:0] id, input bit dir);
        mispred_valid = 1; mispred_tid = tid; mispred_id = id; mispred_taken = dir;
    endtask

    task automatic flush(input bit tid);
        flush_valid = 1; flush_tid = tid;
    endtask

    bit wrap_dirs [10] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        rst_l = 0;
        pred_valid = 0; pred_tid = 0; pred_taken = 0;
        retire_valid = 0; retire_tid = 0; retire_taken = 0;
        mispred_valid = 0; mispred_tid = 0; mispred_id = 0; mispred_taken = 0;
        flush_valid = 0; flush_tid = 0;
        repeat (2) @(posedge clk);
        #1 rst_l = 1;
        settle();
        chk("rst_ghr", int'(ghr), 0);
        chk("rst_empty", int'(ckpt_empty), 3);
        chk("rst_full", int'(ckpt_full), 0);
        chk("rst_ready", int'(pred_ready), 1);

        // T,T,N on thread 0
        nx(); pred(0, 1); settle(); chk("a_id0", int'(pred_ckpt_id), 0);
        nx(); pred(0, 1); settle(); chk("a_id1", int'(pred_ckpt_id), 1);
        nx(); pred(0, 0); settle(); chk("a_id2", int'(pred_ckpt_id), 2);
        idle();
        chk("a_ghr0", int'(ghr[7:0]), 8'h06);
        chk("a_empty0", int'(ckpt_empty[0]), 0);
        chk("a_ghr1", int'(ghr[15:8]), 0);

        // Mispredict id1 as taken restores from its checkpoint (8'h01)
        nx(); mispred(0, 2'd1, 1); settle();
        idle();
        chk("c_ghr0", int'(ghr[7:0]), 8'h03);
        nx(); pred(0, 0); settle(); chk("c_next_id", int'(pred_ckpt_id), 2);

        // Retire T,T then flush
        nx(); retire(0, 1); settle();
        nx(); retire(0, 1); settle();
        nx(); flush(0); settle();
        idle();
        chk("d_ghr0", int'(ghr[7:0]), 8'h03);
        chk("d_empty0", int'(ckpt_empty[0]), 1);

        // Flush beats mispredict beats predict on the same thread
        nx(); pred(0, 1); settle(); chk("f_id", int'(pred_ckpt_id), 2);
        nx(); flush(0); mispred(0, 2'd2, 0); pred(0, 1); settle();
        chk("f_ready_blocked", int'(pred_ready), 0);
        idle();
        chk("f_ghr0", int'(ghr[7:0]), 8'h03);
        chk("f_empty0", int'(ckpt_empty[0]), 1);
        nx(); pred(0, 1); settle();
        nx(); flush(0); pred(1, 1); settle();
        chk("f_t1_ready", int'(pred_ready), 1);
        chk("f_t1_id", int'(pred_ckpt_id), 0);
        idle();
        chk("f_ghr0b", int'(ghr[7:0]), 8'h03);
        chk("f_ghr1", int'(ghr[15:8]), 8'h01);

        // Fill thread 1
        nx(); pred(1, 0); settle(); chk("e_id1", int'(pred_ckpt_id), 1);
        nx(); pred(1, 1); settle(); chk("e_id2", int'(pred_ckpt_id), 2);
        nx(); pred(1, 1); settle(); chk("e_id3", int'(pred_ckpt_id), 3);
        idle();
        chk("e_full1", int'(ckpt_full[1]), 1);
        chk("e_ghr1", int'(ghr[15:8]), 8'h0B);
        nx(); pred(1, 0); settle(); chk("e_ready_full", int'(pred_ready), 0);
        nx(); pred(1, 0); retire(1, 1); settle(); chk("e_ready_full_retire", int'(pred_ready), 0);
        nx(); pred(1, 0); settle();
        chk("e_ready_after", int'(pred_ready), 1);
        chk("e_id_after", int'(pred_ckpt_id), 0);
        idle();
        chk("e_ghr1b", int'(ghr[15:8]), 8'h16);
        chk("e_full1b", int'(ckpt_full[1]), 1);
        nx(); flush(1); settle();
        idle();
        chk("e_flush_ghr1", int'(ghr[15:8]), 8'h01);
        chk("e_flush_empty1", int'(ckpt_empty[1]), 1);

        // Pointer wrap with overlapping predict/retire
        nx(); pred(0, wrap_dirs[0]); settle();
        for (int k = 1; k < 10; k++) begin
            nx(); pred(0, wrap_dirs[k]); retire(0, wrap_dirs[k-1]); settle();
            chk("g_ready", int'(pred_ready), 1);
        end
        nx(); retire(0, wrap_dirs[9]); settle();
        idle();
        chk("g_ghr0", int'(ghr[7:0]), 8'hCB);
        chk("g_empty0", int'(ckpt_empty[0]), 1);
        nx(); flush(0); settle();
        idle();
        chk("g_commit_eq_spec", int'(ghr[7:0]), 8'hCB);

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eh2_bp_ghr_tracker.md
# eh2_bp_ghr_tracker

Maintains the per-thread global branch history register (GHR) for the EH2 branch predictor and feeds `eh2_btb_ghr_hash` directly. Speculatively shifts in each predicted branch direction at fetch, checkpoints the pre-shift history per in-flight branch, restores on mispredict or flush, and tracks a committed GHR updated at retire. Sits between IFU branch-prediction logic (producer of predictions) and the BHT index hash (consumer of `ghr`).

## Interface
- `GHR_SIZE`, 8: history length in bits; matches `BHT_GHR_SIZE`.
- `NUM_THREADS`, 2: hardware threads; one history context each.
- `CKPT_DEPTH`, 4: in-flight branch checkpoints per thread; power of two, ≥2.
- `clk` in 1: single clock.
- `rst_l` in 1: reset, asynchronous, active-low.
- `pred_valid` in 1: a branch was predicted this cycle.
- `pred_tid` in log2(NUM_THREADS): thread of prediction.
- `pred_taken` in 1: predicted direction.
- `pred_ready` out 1: prediction accepted this cycle (combinational).
- `pred_ckpt_id` out log2(CKPT_DEPTH): checkpoint tag assigned to accepted prediction.
- `retire_valid`, `retire_tid`, `retire_taken` in 1/tid/1: oldest branch of thread resolves and commits.
- `mispred_valid`, `mispred_tid`, `mispred_id`, `mispred_taken` in 1/tid/ckpt/1: branch `mispred_id` resolved opposite to prediction; actual direction given.
- `flush_valid`, `flush_tid` in 1/tid: thread pipeline flush (trap, fence); discard all speculation.
- `ghr` out NUM_THREADS×GHR_SIZE: registered speculative history per thread, to hash.
- `ckpt_full`, `ckpt_empty` out NUM_THREADS each: checkpoint buffer status.

## Operation
- Per thread: `ghr_spec`, `ghr_commit`, checkpoint array `ckpt[CKPT_DEPTH]`, head/tail pointers with one extra wrap bit.
- Shift rule everywhere: `new = {old[GHR_SIZE-2:0], dir}`; bit 0 is newest.
- Accept: `pred_ready = !ckpt_full[t] && !mispred(t) && !flush(t)`. On accept: `ckpt[tail] <= ghr_spec`, `ghr_spec <= shift(ghr_spec, pred_taken)`, `tail++`; `pred_ckpt_id = tail` (pre-increment, low bits).
- Retire: `ghr_commit <= shift(ghr_commit, retire_taken)`, `head++`. Retire when empty: ignored, assertion fires.
- Mispredict: `ghr_spec <= shift(ckpt[mispred_id], mispred_taken)`; `tail <= mispred_id + 1` (wrap bit recomputed relative to head); younger entries discarded, mispredicted entry kept until retire. `mispred_id` outside [head, tail): assertion, no state change.
- Flush: `ghr_spec <= ghr_commit_next` (includes same-cycle retire); `tail <= head_next`.
- Per-thread priority: flush > mispredict > prediction. Retire is independent and applies in the same cycle as any of them.
- Different threads’ events in the same cycle are fully independent.
- `ckpt_full` = pointers equal but wrap bits differ; `ckpt_empty` = pointers and wrap bits equal.

## Timing
- All state updates at `posedge clk`; `ghr` reflects an update the following cycle (latency 1).
- `pred_ready`, `pred_ckpt_id` are combinational from same-cycle inputs and state.
- Reset (async assert, sync release): `ghr`=0, `ghr_commit`=0, head=tail=0, `ckpt_empty`=all 1, `ckpt_full`=0, `pred_ready` reflects empty state. Checkpoint contents unreset.
- Reset mid-operation drops all speculation; no restoration.
- Full plus same-cycle retire: prediction still rejected (ready depends on registered full).

## Structure
- Shared package (`eh2_pkg`): `ghr_t` (GHR_SIZE vector), `ghr_ckpt_id_t`, and a `ghr_shift` function.
- One sub-module `eh2_bp_ghr_thread` (single-thread context) instantiated NUM_THREADS times via generate; top decodes tids and muxes `pred_ready`/`pred_ckpt_id`.

## Test plan
- Reset, then predict T,T,N on tid0 → `ghr[0]`=8'h06, ids 0,1,2, `ckpt_empty[0]`=0; `ghr[1]` stays 0.
- Fill 4 predictions tid1 → `ckpt_full[1]`=1, 5th `pred_valid` gives `pred_ready`=0, `ghr[1]` unchanged; retire one → next cycle accepted with id 0.
- From ghr 8'h06 with ids 0..2 in flight, mispredict id1 taken → `ghr`=8'h03 next cycle, tail=2, next prediction id 2.
- Retire T,T then flush tid0 with 3 in flight → `ghr[0]`=8'h03, `ckpt_empty[0]`=1.
- Same-cycle flush+mispredict+predict tid0 → flush result only, `pred_ready`=0; concurrent tid1 predict accepted.
- Pointer wrap: 10 predict/retire pairs → ids cycle 0..3, never full, `ghr_commit` equals `ghr_spec` after drain.
